weight_bram_writer: RTL and testbench

WEIGHT_BRAM_WRITER -- requirements
Module: weight_bram_writer

---
 rtl/weight_bram_writer.sv | 117 +++++++++++
 tb/tb_weight_bram_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_writer.sv
// Packs SW-bit stream beats into 5*MAC_NUM-bit weight words and writes them alternately to BRAM ports A/B.
// Latency: last beat of a word at cycle t -> write strobe at t+1 -> s_ready (or done) at t+2.
// Backpressure: s_ready is high only in FILL; s_valid low stalls packing with no state change.
module weight_bram_writer #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int S_DATA_WIDTH       = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [BRAM_ADDRESS_WIDTH-1:0]   base_addr,
    input  logic [BRAM_ADDRESS_WIDTH:0]     num_words,
    input  logic [S_DATA_WIDTH-1:0]         s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [5*MAC_NUM-1:0]            bram_data_A,
    output logic [5*MAC_NUM-1:0]            bram_data_B,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_A,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_B,
    output logic                            bram_we_A,
    output logic                            bram_we_B,
    output logic                            busy,
    output logic                            done,
    output logic [BRAM_ADDRESS_WIDTH:0]     words_written
);
    localparam int AW    = BRAM_ADDRESS_WIDTH;
    localparam int SW    = S_DATA_WIDTH;
    localparam int WW    = 5 * MAC_NUM;
    localparam int BEATS = (WW + SW - 1) / SW;
    localparam int PW    = BEATS * SW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  base_q;
    logic [AW:0]    num_q;
    logic [CW-1:0]  beat_cnt;
    logic [PW-1:0]  pack_q;
    logic [WW-1:0]  hold_a, hold_b;
    logic [AW-1:0]  wr_addr;
    logic           beat_xfer, last_beat, bank, more;

    assign beat_xfer = s_valid && (state == FILL);
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign bank      = words_written[0];
    // One extra bit so i+1 cannot overflow when num_words is at its maximum
    assign more      = ({1'b0, words_written} + (AW+2)'(1)) < {1'b0, num_q};
    assign wr_addr   = base_q + words_written[AW:1];

    assign s_ready        = (state == FILL);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign bram_we_A      = (state == WRITE) && !bank;
    assign bram_we_B      = (state == WRITE) && bank;
    assign bram_address_A = wr_addr;
    assign bram_address_B = wr_addr;
    assign bram_data_A    = bram_we_A ? pack_q[WW-1:0] : hold_a;
    assign bram_data_B    = bram_we_B ? pack_q[WW-1:0] : hold_b;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_words != '0) ? FILL : DONE;
            FILL:    if (beat_xfer && last_beat) state_nxt = WRITE;
            WRITE:   state_nxt = more ? FILL : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q        <= '0;
            num_q         <= '0;
            beat_cnt      <= '0;
            pack_q        <= '0;
            hold_a        <= '0;
            hold_b        <= '0;
            words_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        num_q         <= num_words;
                        beat_cnt      <= '0;
                        pack_q        <= '0;
                        words_written <= '0;
                    end
                end
                FILL: begin
                    if (beat_xfer) begin
                        // Beat k lands at bits [k*SW +: SW]; excess MSBs of the last beat never reach the BRAM
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CW'(k)) pack_q[k*SW +: SW] <= s_data;
                        end
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (bank) hold_b <= pack_q[WW-1:0];
                    else      hold_a <= pack_q[WW-1:0];
                    words_written <= words_written + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_bram_writer.sv
// Directed bench for weight_bram_writer at default parameters (MAC_NUM=256, SW=32, BEATS=40).
// Beat k of word w carries (w<<16)|k, so every expected word, address and bank is computed here.
module tb_weight_bram_writer;
    localparam int MAC_NUM = 256;
    localparam int AW      = 12;
    localparam int SW      = 32;
    localparam int WW      = 5 * MAC_NUM;
    localparam int BEATS   = 40;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     num_words;
    logic [SW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [WW-1:0]   bram_data_A, bram_data_B;
    logic [AW-1:0]   bram_address_A, bram_address_B;
    logic            bram_we_A, bram_we_B;
    logic            busy, done;
    logic [AW:0]     words_written;

    int errors = 0;
    int checks = 0;
    int we_a_cnt = 0;
    int we_b_cnt = 0;

    weight_bram_writer #(
        .MAC_NUM(MAC_NUM), .BRAM_ADDRESS_WIDTH(AW), .S_DATA_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bram_data_A(bram_data_A), .bram_data_B(bram_data_B),
        .bram_address_A(bram_address_A), .bram_address_B(bram_address_B),
        .bram_we_A(bram_we_A), .bram_we_B(bram_we_B),
        .busy(busy), .done(done), .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_we_A) we_a_cnt++;
        if (bram_we_B) we_b_cnt++;
    end

    function automatic logic [SW-1:0] pat(input int w, input int k);
        return SW'((w << 16) | k);
    endfunction

    function automatic logic [WW-1:0] word_of(input int w);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < BEATS; k++) r[k*SW +: SW] = pat(w, k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic chk_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] req);
        int bad;
        checks++;
        assert (obs === req) else begin
            errors++;
            bad = 0;
            for (int k = BEATS - 1; k >= 0; k--) if (obs[k*SW +: SW] !== req[k*SW +: SW]) bad = k;
            $error("FAIL %s: beat %0d observed %h expected %h", tag, bad, obs[bad*SW +: SW], req[bad*SW +: SW]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_we_A"}, 64'(bram_we_A), 0);
        chk({tag, "_we_B"}, 64'(bram_we_B), 0);
        chk({tag, "_addr_A"}, 64'(bram_address_A), 0);
        chk({tag, "_addr_B"}, 64'(bram_address_B), 0);
        chk({tag, "_words_written"}, 64'(words_written), 0);
        chk_word({tag, "_data_A"}, bram_data_A, '0);
        chk_word({tag, "_data_B"}, bram_data_B, '0);
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = n;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 1);
    endtask

    // Entered on a negedge with the DUT in FILL; returns on the negedge after the last transfer.
    task automatic send_beats(input int w, input int nbeats, input bit gaps, input bit inject);
        int  k = 0;
        int  guard = 0;
        bit  inj = 1'b0;
        bit  xfer;
        while (k < nbeats && guard < 4000) begin
            start = 1'b0;
            if (inject && k == 10 && !inj) begin
                start = 1'b1; base_addr = 12'h555; num_words = 13'd7; inj = 1'b1;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
            end else begin
                s_valid = 1'b1; s_data = pat(w, k);
            end
            xfer = s_valid && s_ready;
            @(negedge clk);
            guard++;
            if (xfer) k++;
        end
        start = 1'b0; s_valid = 1'b0;
        chk("beats_accepted", 64'(k), 64'(nbeats));
    endtask

    task automatic run_load(input logic [AW-1:0] base, input int n, input bit gaps, input bit inject);
        int a0 = we_a_cnt;
        int b0 = we_b_cnt;
        logic [AW-1:0] ea;
        do_start(base, (AW+1)'(n));
        if (n == 0) begin
            chk("zero_done", 64'(done), 1);
            chk("zero_s_ready", 64'(s_ready), 0);
        end
        for (int w = 0; w < n; w++) begin
            send_beats(w, BEATS, gaps, inject && w == 0);
            ea = base + AW'(w >> 1);
            chk("we_A", 64'(bram_we_A), 64'(w % 2 == 0));
            chk("we_B", 64'(bram_we_B), 64'(w % 2 == 1));
            chk("addr_A", 64'(bram_address_A), 64'(ea));
            chk("addr_B", 64'(bram_address_B), 64'(ea));
            chk("write_s_ready", 64'(s_ready), 0);
            chk("write_index", 64'(words_written), 64'(w));
            if (w % 2 == 0) chk_word("data_A", bram_data_A, word_of(w));
            else            chk_word("data_B", bram_data_B, word_of(w));
            if (w > 0) begin
                if (w % 2 == 0) chk_word("hold_B", bram_data_B, word_of(w - 1));
                else            chk_word("hold_A", bram_data_A, word_of(w - 1));
            end
            @(negedge clk);
            if (w < n - 1) chk("s_ready_after_write", 64'(s_ready), 1);
            else           chk("done_after_write", 64'(done), 1);
        end
        chk("words_written", 64'(words_written), 64'(n));
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_done", 64'(done), 0);
        chk("words_written_hold", 64'(words_written), 64'(n));
        chk("we_A_count", 64'(we_a_cnt - a0), 64'((n + 1) / 2));
        chk("we_B_count", 64'(we_b_cnt - b0), 64'(n / 2));
    endtask

    initial begin
        int a0, b0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        s_data = '0; s_valid = 1'b0;
        #1;
        chk_all_zero("reset");
        #21 rst_n = 1'b1;

        // start ignored unless pulsed; stream beats while idle are refused
        @(negedge clk);
        s_valid = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 64'(s_ready), 0);
        chk("idle_busy_pre", 64'(busy), 0);
        s_valid = 1'b0;

        run_load(12'h010, 1, 1'b0, 1'b0);
        run_load(12'h020, 3, 1'b0, 1'b0);
        run_load(12'hFFF, 4, 1'b0, 1'b0);
        run_load(12'h020, 3, 1'b1, 1'b1);
        run_load(12'h0AB, 0, 1'b0, 1'b0);

        // reset mid-load after 20 beats of word 0
        a0 = we_a_cnt; b0 = we_b_cnt;
        do_start(12'h100, 13'd2);
        send_beats(0, 20, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", 64'(busy), 0);
        chk("post_reset_s_ready", 64'(s_ready), 0);
        chk("post_reset_no_we", 64'((we_a_cnt - a0) + (we_b_cnt - b0)), 0);
        s_valid = 1'b0;
        run_load(12'h030, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
